// File: rtl/interconnect_cfg_loader.sv
// interconnect_cfg_loader: serial configuration writer for the CLB interconnect muxes.
// Receives an LSB-first bit stream over valid/ready and hunts for SYNC_WORD.
// It then shifts NUM_MUX select codes into a shadow register, range-checks them
// and commits them atomically to the mux select lines.
// Optional feature: define ICU_CFG_PARITY_EN to expect one even-parity bit after the data.
// Ports:
//   clk, rst_b                  clock, asynchronous active-low reset
//   cfg_start                   one-cycle pulse that (re)starts a load
//   cfg_din/cfg_valid/cfg_ready serial bit handshake
//   interconnect_switch_bus     committed select codes, mux k at [SEL_W*k +: SEL_W]
//   prgm_b                      high once any configuration has been committed
//   CLB_prgm_b                  low enables the CLB muxes, high freezes them
//   cfg_done / cfg_err          result of the last load
module interconnect_cfg_loader #(
  parameter int              NUM_MUX   = 4,
  parameter int              SEL_W     = 6,
  parameter logic [SEL_W-1:0] SEL_MAX  = 6'd39,
  parameter logic [7:0]      SYNC_WORD = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     cfg_start,
  input  logic                     cfg_din,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  output logic [NUM_MUX*SEL_W-1:0] interconnect_switch_bus,
  output logic                     prgm_b,
  output logic                     CLB_prgm_b,
  output logic                     cfg_done,
  output logic                     cfg_err
);
  localparam int N  = NUM_MUX * SEL_W;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LOAD, S_PAR, S_CHECK, S_DONE, S_ERR} state_t;

`ifdef ICU_CFG_PARITY_EN
  localparam state_t LOAD_END = S_PAR;
`else
  localparam state_t LOAD_END = S_CHECK;
`endif

  state_t          r_state, w_next;
  logic [7:0]      r_win;
  logic [7:0]      w_win;
  logic [N-1:0]    r_shadow;
  logic [CW-1:0]   r_cnt;
  logic            w_xfer;
  logic            w_range_ok;
  logic            w_ok;

  // cfg_start has priority: a bit offered in the same cycle is dropped
  assign w_xfer = cfg_valid && cfg_ready && !cfg_start;
  // new bits enter at the MSB so an LSB-first byte lands in natural order
  assign w_win  = {cfg_din, r_win[7:1]};

  always_comb begin
    w_range_ok = 1'b1;
    for (int k = 0; k < NUM_MUX; k++)
      if (r_shadow[SEL_W*k +: SEL_W] > SEL_MAX) w_range_ok = 1'b0;
  end

`ifdef ICU_CFG_PARITY_EN
  // running XOR over data and parity bits; zero means even parity held
  logic r_par;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) r_par <= 1'b0;
    else if (cfg_start) r_par <= 1'b0;
    else if (w_xfer && (r_state == S_LOAD || r_state == S_PAR)) r_par <= r_par ^ cfg_din;
  assign w_ok = w_range_ok && !r_par;
`else
  assign w_ok = w_range_ok;
`endif

  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (cfg_start) w_next = S_SYNC;
    else
      case (r_state)
        S_SYNC:  if (w_xfer && w_win == SYNC_WORD) w_next = S_LOAD;
        S_LOAD:  if (w_xfer && r_cnt == LAST) w_next = LOAD_END;
        S_PAR:   if (w_xfer) w_next = S_CHECK;
        S_CHECK: w_next = w_ok ? S_DONE : S_ERR;
        default: ;
      endcase
  end

  always_comb cfg_ready = (r_state == S_SYNC) || (r_state == S_LOAD) || (r_state == S_PAR);

  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      r_win                   <= '0;
      r_shadow                <= '0;
      r_cnt                   <= '0;
      interconnect_switch_bus <= '0;
      prgm_b                  <= 1'b0;
      CLB_prgm_b              <= 1'b1;
      cfg_done                <= 1'b0;
      cfg_err                 <= 1'b0;
    end else if (cfg_start) begin
      r_win      <= '0;
      r_shadow   <= '0;
      r_cnt      <= '0;
      CLB_prgm_b <= 1'b1;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      if (w_xfer && r_state == S_SYNC) begin
        r_win <= w_win;
        if (w_win == SYNC_WORD) r_cnt <= '0;
      end
      if (w_xfer && r_state == S_LOAD) begin
        r_shadow <= {cfg_din, r_shadow[N-1:1]};
        r_cnt    <= r_cnt + ONE;
      end
      // the bus only ever sees a fully checked shadow image
      if (r_state == S_CHECK) begin
        if (w_ok) begin
          interconnect_switch_bus <= r_shadow;
          prgm_b                  <= 1'b1;
          CLB_prgm_b              <= 1'b0;
          cfg_done                <= 1'b1;
        end else
          cfg_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_interconnect_cfg_loader.sv
// tb_interconnect_cfg_loader: table-driven bench for interconnect_cfg_loader plus reset/abort sequences.
module tb_interconnect_cfg_loader;
`ifdef ICU_CFG_PARITY_EN
  localparam int FB = 25;
  localparam bit PAR_ON = 1'b1;
`else
  localparam int FB = 24;
  localparam bit PAR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_din = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [23:0] bus;
  logic        prgm_b;
  logic        clb_prgm_b;
  logic        cfg_done;
  logic        cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  interconnect_cfg_loader dut (
    .clk                     (clk),
    .rst_b                   (rst_b),
    .cfg_start               (cfg_start),
    .cfg_din                 (cfg_din),
    .cfg_valid               (cfg_valid),
    .cfg_ready               (cfg_ready),
    .interconnect_switch_bus (bus),
    .prgm_b                  (prgm_b),
    .CLB_prgm_b              (clb_prgm_b),
    .cfg_done                (cfg_done),
    .cfg_err                 (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic        par;
    bit          stall;
    logic        exp_done;
    logic [23:0] exp_bus;
  } vec_t;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit stall);
    int n;
    if (stall) repeat ($urandom_range(1, 5)) @(negedge clk);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_din   = b;
    n = 0;
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake_timeout: got ready=%b expected 1", cfg_ready);
      cfg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  // junk 1,1,0, sync A5 LSB-first, then the first nbits of f (data then parity)
  task automatic send_frame(input logic [24:0] f, input int nbits, input bit stall);
    logic [7:0] s;
    s = 8'hA5;
    send_bit(1'b1, stall);
    send_bit(1'b1, stall);
    send_bit(1'b0, stall);
    for (int i = 0; i < 8; i++) send_bit(s[i], stall);
    for (int i = 0; i < nbits; i++) send_bit(f[i], stall);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cfg_start = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bus"},   bus, 24'h0);
    chk({tag, "_prgm"},  {23'h0, prgm_b}, 24'h0);
    chk({tag, "_clb"},   {23'h0, clb_prgm_b}, 24'h1);
    chk({tag, "_ready"}, {23'h0, cfg_ready}, 24'h0);
    chk({tag, "_done"},  {23'h0, cfg_done}, 24'h0);
    chk({tag, "_err"},   {23'h0, cfg_err}, 24'h0);
  endtask

  task automatic chk_result(input string tag, input logic done, input logic [23:0] b, input logic p);
    chk({tag, "_done"},  {23'h0, cfg_done}, {23'h0, done});
    chk({tag, "_err"},   {23'h0, cfg_err}, {23'h0, !done});
    chk({tag, "_clb"},   {23'h0, clb_prgm_b}, {23'h0, !done});
    chk({tag, "_bus"},   bus, b);
    chk({tag, "_prgm"},  {23'h0, prgm_b}, {23'h0, p});
    chk({tag, "_ready"}, {23'h0, cfg_ready}, 24'h0);
  endtask

  vec_t        vecs[9];
  logic [23:0] prev_bus;
  logic        prev_prgm;

  initial begin
    vecs[0] = '{24'h7E7400, 1'b0, 1'b0, 1'b1,    24'h7E7400};
    vecs[1] = '{24'h7E8400, 1'b1, 1'b0, 1'b0,    24'h7E7400};
    vecs[2] = '{24'h7E8400, 1'b0, 1'b0, 1'b0,    24'h7E7400};
    vecs[3] = '{24'h7E7400, 1'b1, 1'b0, !PAR_ON, 24'h7E7400};
    vecs[4] = '{24'h9E79E7, 1'b0, 1'b0, 1'b1,    24'h9E79E7};
    vecs[5] = '{24'h00003F, 1'b0, 1'b0, 1'b0,    24'h9E79E7};
    vecs[6] = '{24'hA00000, 1'b0, 1'b0, 1'b0,    24'h9E79E7};
    vecs[7] = '{24'h7E7400, 1'b0, 1'b1, 1'b1,    24'h7E7400};
    vecs[8] = '{24'h000000, 1'b0, 1'b0, 1'b1,    24'h000000};

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_b = 1'b1;
    cfg_valid = 1'b1;
    cfg_din = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", {23'h0, cfg_ready}, 24'h0);
    cfg_valid = 1'b0;

    prev_bus  = 24'h0;
    prev_prgm = 1'b0;
    for (int v = 0; v < 9; v++) begin
      pulse_start();
      chk($sformatf("v%0d_start_ready", v), {23'h0, cfg_ready}, 24'h1);
      chk($sformatf("v%0d_start_clb", v),   {23'h0, clb_prgm_b}, 24'h1);
      chk($sformatf("v%0d_start_done", v),  {23'h0, cfg_done}, 24'h0);
      chk($sformatf("v%0d_start_bus", v),   bus, prev_bus);
      send_frame({vecs[v].par, vecs[v].data}, FB, vecs[v].stall);
      @(negedge clk);
      chk($sformatf("v%0d_check_done", v), {23'h0, cfg_done}, 24'h0);
      chk($sformatf("v%0d_check_bus", v),  bus, prev_bus);
      @(negedge clk);
      if (vecs[v].exp_done) prev_prgm = 1'b1;
      chk_result($sformatf("v%0d", v), vecs[v].exp_done, vecs[v].exp_bus, prev_prgm);
      prev_bus = vecs[v].exp_bus;
    end

    // reset after 10 data bits: everything back to reset values at once
    pulse_start();
    send_frame({1'b0, 24'h7E7400}, 10, 1'b0);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_b = 1'b1;
    pulse_start();
    send_frame({1'b0, 24'h7E7400}, FB, 1'b0);
    repeat (2) @(negedge clk);
    chk_result("after_rst", 1'b1, 24'h7E7400, 1'b1);

    // abort mid-LOAD: partial data must never reach the bus
    pulse_start();
    send_frame({1'b1, 24'hFFFFFF}, 12, 1'b0);
    pulse_start();
    chk("abort_bus", bus, 24'h7E7400);
    chk("abort_ready", {23'h0, cfg_ready}, 24'h1);
    send_frame({1'b0, 24'h9E79E7}, FB, 1'b0);
    repeat (2) @(negedge clk);
    chk_result("abort", 1'b1, 24'h9E79E7, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/interconnect_cfg_loader.md
# interconnect_cfg_loader

Configuration writer for the CLB interconnect multiplexers. It receives a serial configuration stream over a valid/ready handshake and locates a sync word. It then shifts in one 6-bit select code per interconnect mux, range-checks each code, and commits the codes atomically to the mux select lines. It also drives the `prgm_b` / `CLB_prgm_b` qualifiers that the interconnect units use to gate their outputs.

## Interface
Parameters:
- `NUM_MUX`, 4: number of interconnect units configured; minimum 1.
- `SEL_W`, 6: select code width per mux; fixed at 6 for the current interconnect unit.
- `SEL_MAX`, 39: highest legal select code (6'b100111); any code above this is illegal.
- `SYNC_WORD`, 8'hA5: frame sync pattern.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_b` input 1: asynchronous, active-low reset.
- `cfg_start` input 1: single-cycle pulse that begins a load.
- `cfg_din` input 1: serial configuration bit.
- `cfg_valid` input 1: `cfg_din` is valid this cycle.
- `cfg_ready` output 1: loader accepts a bit this cycle.
- `interconnect_switch_bus` output NUM_MUX*SEL_W: committed select codes; mux k is bits [SEL_W*k +: SEL_W].
- `prgm_b` output 1: high once any valid configuration has been committed.
- `CLB_prgm_b` output 1: low means the CLB muxes are enabled; high freezes them.
- `cfg_done` output 1: last load committed successfully.
- `cfg_err` output 1: last load rejected.

## Operation
- A bit transfers on a rising edge when `cfg_valid && cfg_ready`.
- Bits arrive LSB-first; mux 0 is sent first.
- States:
  - IDLE: `cfg_ready`=0. On `cfg_start` go to SYNC.
  - SYNC: `cfg_ready`=1. Maintain an 8-bit sliding window, shifting new bits in at the MSB so that an LSB-first stream reassembles correctly. When the window equals `SYNC_WORD`, clear the bit counter and go to LOAD. The sync search is unlimited.
  - LOAD: `cfg_ready`=1. Shift bits into a shadow register and count them. After NUM_MUX*SEL_W bits go to PAR if `ICU_CFG_PARITY_EN` is defined, otherwise go to CHECK.
  - PAR: `cfg_ready`=1. Accept one parity bit, then go to CHECK.
  - CHECK: `cfg_ready`=0, one cycle. Evaluate the shadow register:
    - If every code is ≤ `SEL_MAX` and parity passes, commit and go to DONE.
    - Otherwise go to ERR.
  - DONE / ERR: `cfg_ready`=0. `cfg_start` re-enters SYNC.
- Entering SYNC from any state:
  - `CLB_prgm_b`<=1, `cfg_done`<=0, `cfg_err`<=0.
  - `prgm_b` and `interconnect_switch_bus` hold their values.
- `cfg_start` during SYNC, LOAD or PAR aborts the current load and restarts SYNC. The shadow register and bit counter are cleared.
- Commit on the CHECK→DONE edge:
  - `interconnect_switch_bus`<=shadow.
  - `prgm_b`<=1, `CLB_prgm_b`<=0, `cfg_done`<=1.
- On the CHECK→ERR edge:
  - `cfg_err`<=1.
  - `CLB_prgm_b` stays 1.
  - `interconnect_switch_bus` and `prgm_b` keep their previous committed values; a partial configuration is never visible.
- Range check: each SEL_W-bit field is compared unsigned against `SEL_MAX`.
- The bit counter is sized `$clog2(NUM_MUX*SEL_W+1)` and never wraps within a frame.

## Timing
- Reset values:
  - state IDLE.
  - `interconnect_switch_bus`=0, `prgm_b`=0, `CLB_prgm_b`=1.
  - `cfg_ready`=0, `cfg_done`=0, `cfg_err`=0.
  - Shadow register and counters cleared.
- `rst_b` low mid-load: immediate return to reset values; no commit occurs.
- `cfg_ready` goes high one cycle after `cfg_start` is sampled.
- `cfg_valid` low stalls the loader without penalty. The state, window and counter hold.
- Latency: after the final bit handshake (parity bit, or last data bit without parity), CHECK occupies the next cycle. Outputs update at the edge ending CHECK, i.e. two edges after the final handshake.
- `cfg_start` and a bit handshake in the same cycle: `cfg_start` wins and the bit is discarded.

## Configuration
- `ICU_CFG_PARITY_EN`, defined:
  - The PAR state exists.
  - One even-parity bit follows the data; the data bits plus the parity bit must contain an even number of ones.
  - A mismatch causes ERR.
- `ICU_CFG_PARITY_EN`, undefined:
  - There is no PAR state and no parity bit is expected.
  - LOAD goes directly to CHECK; only the range check applies.

## Test plan
- Nominal load (NUM_MUX=4, parity on): 3 junk bits 1,1,0, then sync bits 1,0,1,0,0,1,0,1, then codes 6'h00, 6'h10, 6'h27, 6'h1F, then parity 0 → `interconnect_switch_bus`=24'h7E7400 two edges after the parity handshake, with `prgm_b`=1, `CLB_prgm_b`=0, `cfg_done`=1.
- Range error: same frame with mux2=6'h28 and parity 1 → `cfg_err`=1, `CLB_prgm_b`=1, bus and `prgm_b` unchanged from the prior commit.
- Parity error: nominal frame with parity bit 1 → ERR; bus unchanged; `cfg_done`=0.
- Stall: nominal frame with `cfg_valid` deasserted for 1–5 random cycles between bits → identical result to the nominal load.
- Reset mid-load: assert `rst_b` low after 10 data bits → all outputs return to reset values immediately; a subsequent `cfg_start` plus the nominal frame loads correctly.
- Abort: `cfg_start` pulsed during LOAD, then a full nominal frame → commits the nominal values; the first partial data is never visible on the bus.
